// File: rtl/shifter_pkg.sv
// Shared shift-mode encoding for the pipelined barrel shifter and its stages.
// Pure declarations: no logic and no latency.
package shifter_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_SLL = 2'b00;
   localparam mode_t MODE_SRL = 2'b01;
   localparam mode_t MODE_SRA = 2'b10;
   localparam mode_t MODE_ROL = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One conditional shift-by-DIST mux plus its stage register; 1 cycle.
// Holds its item while adv_i is low and refills from upstream whenever it is empty or draining.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TAG_W   = 5,
   parameter int DIST    = 1,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               vld_i,
   input  logic [WIDTH-1:0]   dat_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  mode_t              mode_i,
   input  logic [TAG_W-1:0]   tag_i,
   input  logic               sign_i,
   input  logic               adv_i,
   output logic               adv_o,
   output logic               vld_o,
   output logic [WIDTH-1:0]   dat_o,
   output logic [SHAMT_W-1:0] shamt_o,
   output mode_t              mode_o,
   output logic [TAG_W-1:0]   tag_o,
   output logic               sign_o
);

   localparam int BIT = $clog2(DIST);

   logic               vld_q;
   logic [WIDTH-1:0]   dat_d, dat_q;
   logic [SHAMT_W-1:0] shamt_q;
   mode_t              mode_q;
   logic [TAG_W-1:0]   tag_q;
   logic               sign_q;

   // SRA fill uses the sign captured at acceptance, not the partially shifted MSB.
   always_comb begin
      dat_d = dat_i;
      if (shamt_i[BIT]) begin
         case (mode_i)
            MODE_SLL: dat_d = {dat_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
            MODE_SRL: dat_d = {{DIST{1'b0}}, dat_i[WIDTH-1:DIST]};
            MODE_SRA: dat_d = {{DIST{sign_i}}, dat_i[WIDTH-1:DIST]};
            MODE_ROL: dat_d = {dat_i[WIDTH-DIST-1:0], dat_i[WIDTH-1:WIDTH-DIST]};
            default:  dat_d = dat_i;
         endcase
      end
   end

   assign adv_o = !vld_q || adv_i;

   // Payload loads only with a real item, so a bubble leaves the last data in place.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         dat_q   <= '0;
         shamt_q <= '0;
         mode_q  <= MODE_SLL;
         tag_q   <= '0;
         sign_q  <= 1'b0;
      end else begin
         if (adv_o) begin
            vld_q <= vld_i;
         end
         if (adv_o && vld_i) begin
            dat_q   <= dat_d;
            shamt_q <= shamt_i;
            mode_q  <= mode_i;
            tag_q   <= tag_i;
            sign_q  <= sign_i;
         end
      end
   end

   assign vld_o   = vld_q;
   assign dat_o   = dat_q;
   assign shamt_o = shamt_q;
   assign mode_o  = mode_q;
   assign tag_o   = tag_q;
   assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// SLL/SRL/SRA/ROL barrel shifter, one registered stage per shamt bit; latency SHAMT_W cycles.
// Per-stage bubble collapse: in_ready falls only when every stage holds an item and out_ready is low.
module pipelined_barrel_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int TAG_W   = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
);

   // Index 0 is the input port side, index SHAMT_W the output register.
   logic               vld_c   [SHAMT_W+1];
   logic [WIDTH-1:0]   dat_c   [SHAMT_W+1];
   logic [SHAMT_W-1:0] shamt_c [SHAMT_W+1];
   mode_t              mode_c  [SHAMT_W+1];
   logic [TAG_W-1:0]   tag_c   [SHAMT_W+1];
   logic               sign_c  [SHAMT_W+1];
   logic               adv_c   [SHAMT_W+1];

   assign vld_c[0]         = in_valid;
   assign dat_c[0]         = in_data;
   assign shamt_c[0]       = in_shamt;
   assign mode_c[0]        = in_mode;
   assign tag_c[0]         = in_tag;
   assign sign_c[0]        = in_data[WIDTH-1];
   assign adv_c[SHAMT_W]   = out_ready;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      shift_stage #(
         .WIDTH   (WIDTH),
         .TAG_W   (TAG_W),
         .DIST    (1 << k),
         .SHAMT_W (SHAMT_W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .vld_i   (vld_c[k]),
         .dat_i   (dat_c[k]),
         .shamt_i (shamt_c[k]),
         .mode_i  (mode_c[k]),
         .tag_i   (tag_c[k]),
         .sign_i  (sign_c[k]),
         .adv_i   (adv_c[k+1]),
         .adv_o   (adv_c[k]),
         .vld_o   (vld_c[k+1]),
         .dat_o   (dat_c[k+1]),
         .shamt_o (shamt_c[k+1]),
         .mode_o  (mode_c[k+1]),
         .tag_o   (tag_c[k+1]),
         .sign_o  (sign_c[k+1])
      );
   end

   assign in_ready  = adv_c[0];
   assign out_valid = vld_c[SHAMT_W];
   assign out_data  = dat_c[SHAMT_W];
   assign out_tag   = tag_c[SHAMT_W];

   logic unused_last;
   assign unused_last = ^{shamt_c[SHAMT_W], mode_c[SHAMT_W], sign_c[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and randomized bench for pipelined_barrel_shifter (WIDTH=32) against a queue-based reference.
module tb_pipelined_barrel_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   pipelined_barrel_shifter #(.WIDTH(32), .TAG_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
      int          c;
   } exp_t;

   exp_t        sbq[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_acc = 0;
   int          n_emit = 0;
   bit          lat_chk = 1'b0;
   bit          hold_chk = 1'b0;
   logic [31:0] hold_d;
   logic [4:0]  hold_t;

   // Reference shifter written from the mode definitions with plain operators.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] m);
      logic signed [31:0] sd;
      sd = d;
      case (m)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return sd >>> s;
         default: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, score the handshakes of the coming edge, advance.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, input logic [4:0] t, input logic ordy);
      exp_t e;
      logic acc;
      logic emit;
      in_valid  = v;
      in_data   = d;
      in_shamt  = s;
      in_mode   = m;
      in_tag    = t;
      out_ready = ordy;
      #1;
      acc  = rst_n && in_valid && in_ready;
      emit = rst_n && out_valid && out_ready;
      if (hold_chk) begin
         chk("hold_data", {32'd0, out_data}, {32'd0, hold_d});
         chk("hold_tag", {59'd0, out_tag}, {59'd0, hold_t});
      end
      if (emit) begin
         if (sbq.size() == 0) begin
            chk("spurious_output", 64'd1, 64'd0);
         end else begin
            e = sbq.pop_front();
            chk("out_data", {32'd0, out_data}, {32'd0, e.d});
            chk("out_tag", {59'd0, out_tag}, {59'd0, e.t});
            if (lat_chk) chk("latency", 64'(cyc - e.c), 64'd5);
         end
         n_emit++;
      end
      if (acc) begin
         e.d = ref_shift(d, int'(s), m);
         e.t = t;
         e.c = cyc;
         sbq.push_back(e);
         n_acc++;
      end
      hold_chk = rst_n && out_valid && !out_ready;
      hold_d   = out_data;
      hold_t   = out_tag;
      @(posedge clk);
      cyc++;
      if (!rst_n) sbq.delete();
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 5'd0, 2'd0, 5'd0, ordy);
   endtask

   initial begin
      int e0;
      int a0;
      int guard;
      logic [1:0] mm;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_mode   = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      @(negedge clk);

      // Reset state
      idle(2, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Single SLL 1 by 31, with latency check
      lat_chk = 1'b1;
      e0 = n_emit;
      cycle(1'b1, 32'h0000_0001, 5'd31, 2'b00, 5'd3, 1'b1);
      guard = 0;
      while (n_emit == e0 && guard < 10) begin
         idle(1, 1'b1);
         guard++;
      end
      chk("t1_emitted", 64'(n_emit - e0), 64'd1);

      // Back-to-back SRL / SRA / ROL
      e0 = n_emit;
      cycle(1'b1, 32'h8000_0000, 5'd4, 2'b01, 5'd10, 1'b1);
      cycle(1'b1, 32'h8000_0000, 5'd4, 2'b10, 5'd11, 1'b1);
      cycle(1'b1, 32'h8000_0001, 5'd1, 2'b11, 5'd12, 1'b1);
      idle(5, 1'b1);
      chk("b2b_emitted", 64'(n_emit - e0), 64'd3);

      // shamt = 0 in every mode
      e0 = n_emit;
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA5A5_5A5A, 5'd0, 2'(i), 5'(20 + i), 1'b1);
      idle(6, 1'b1);
      chk("shamt0_emitted", 64'(n_emit - e0), 64'd4);

      // Backpressure: fill to capacity, then drain
      lat_chk = 1'b0;
      a0 = n_acc;
      e0 = n_emit;
      for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 5'($urandom), 2'($urandom), 5'(i), 1'b0);
      chk("bp_accepted", 64'(n_acc - a0), 64'd5);
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_release", {63'd0, in_ready}, 64'd1);
      idle(5, 1'b1);
      chk("bp_drained", 64'(n_emit - e0), 64'd5);
      chk("bp_queue_empty", 64'(sbq.size()), 64'd0);

      // Reset with three items in flight
      for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 5'($urandom), 2'($urandom), 5'(i), 1'b0);
      rst_n = 1'b0;
      idle(1, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      e0 = n_emit;
      idle(8, 1'b1);
      chk("midrst_no_stale", 64'(n_emit - e0), 64'd0);
      lat_chk = 1'b1;
      cycle(1'b1, 32'h1234_5678, 5'd8, 2'b11, 5'd7, 1'b1);
      idle(6, 1'b1);
      chk("midrst_new_item", 64'(n_emit - e0), 64'd1);
      lat_chk = 1'b0;

      // Random traffic with random downstream stalls
      a0 = n_acc;
      guard = 0;
      while (n_acc < a0 + 10000 && guard < 40000) begin
         mm = 2'($urandom);
         cycle($urandom_range(0, 4) != 0, $urandom, 5'($urandom), mm, 5'($urandom),
               $urandom_range(0, 3) != 0);
         guard++;
      end
      chk("rand_accepted", 64'(n_acc - a0), 64'd10000);
      guard = 0;
      while (sbq.size() > 0 && guard < 100) begin
         idle(1, 1'b1);
         guard++;
      end
      chk("rand_drained", 64'(sbq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the combinational 32-bit left shifter. Performs logical-left, logical-right, arithmetic-right and rotate-left shifts.
- Has one registered mux level per shift-amount bit and a valid/ready handshake with per-stage bubble collapse.
- Sits between the register-read operands and the ALU result mux. Serves shift instructions in the multi-cycle and pipelined datapath variants.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two and at least 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside the data.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input operand valid
- in_ready  output  1  block can accept an operand this cycle
- in_data  input  WIDTH  value to shift
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  shifted result
- out_tag  output  TAG_W  tag matching out_data

Behaviour:
- Reset: clk and rst_n only; reset is synchronous, active-low. While rst_n=0 at a clock edge:
  - all stage valid bits are cleared;
  - out_valid=0, out_data=0, out_tag=0;
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards every in-flight item; no partial result is emitted.
- Pipeline: SHAMT_W stages, k = 0..SHAMT_W-1. Each stage registers {valid, data, shamt, mode, tag}.
  - Stage k applies a shift of 2^k when shamt[k]=1, otherwise passes the data through.
  - The last stage register is the output (out_* driven directly from it).
- Latency: SHAMT_W cycles from the accepting edge (in_valid && in_ready) to out_valid=1, when there is no backpressure. That is 5 cycles for WIDTH=32. Throughput is 1 result per cycle.
- Stage fill per mode:
  - SLL: zeros fill the low bits.
  - SRL: zeros fill the high bits.
  - SRA: the original in_data[WIDTH-1] fills the high bits. The sign bit is carried in the stage register; it is not re-sampled from partially shifted data.
  - ROL: bits shifted out at the top re-enter at the bottom.
- shamt=0: data is unchanged in every mode, but still takes the full latency.
- Handshake, per-stage advance:
  - adv[last] = !v[last] || out_ready.
  - adv[k] = !v[k] || adv[k+1].
  - in_ready = adv[0], a combinational chain.
  - A stage that holds a valid item and cannot advance keeps all its fields stable.
- Bubbles: empty stages are filled from upstream even while the output is stalled.
  - Capacity is SHAMT_W items.
  - With out_ready held at 0, in_ready drops only when all SHAMT_W stages are valid.
- Output rules:
  - out_data and out_tag must stay stable while out_valid=1 && out_ready=0.
  - out_data keeps its last value when out_valid=0; it is not zeroed.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts and emits in the same cycle, so there is no throughput loss. in_ready must not depend on in_valid.
- Ordering: strictly in order; no reordering, no dropping, no duplication.
- in_mode and in_shamt are sampled only at acceptance and are not re-read afterwards.

Decomposition:
- Shared package shifter_pkg:
  - mode constants MODE_SLL=2'b00, MODE_SRL=2'b01, MODE_SRA=2'b10, MODE_ROL=2'b11;
  - a typedef for the 2-bit mode.
- Sub-module shift_stage, instantiated SHAMT_W times through a generate loop:
  - parameters WIDTH, TAG_W, DIST (2^k);
  - one conditional-shift mux plus the stage register, with in/out valid and advance.

Test Plan:
- Reset then one SLL of in_data=32'h0000_0001, shamt=31, tag=3 → after 5 cycles out_valid=1, out_data=32'h8000_0000, out_tag=3.
- Back-to-back, one per cycle, out_ready=1:
  - SRL 32'h8000_0000 by 4 → 32'h0800_0000;
  - SRA 32'h8000_0000 by 4 → 32'hF800_0000;
  - ROL 32'h8000_0001 by 1 → 32'h0000_0003.
  - Required response: results on consecutive cycles, in issue order.
- Backpressure: out_ready=0 with continuous in_valid. Exactly 5 items are accepted, then in_ready=0 and out_data stays stable. Raising out_ready then drains one item per cycle in order, and in_ready=1 again the same cycle.
- shamt=0 in all four modes with 32'hA5A5_5A5A → output equals input after 5 cycles.
- rst_n=0 for one cycle while 3 items are in flight → out_valid=0 the next cycle and no stale item ever appears. A new item then takes 5 cycles.
- Random mode/shamt/data with random out_ready toggling, 10k items → every result matches the reference model and the tag sequence is preserved.
